// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall detection, branch/jump flush and Execute-stage forwarding selects.
// Latency: all outputs are combinational from tracked state plus Decode inputs; tracked state updates in one cycle.
// Backpressure: stallF/stallD hold fetch/decode for a not-yet-forwardable producer; pcsrcE overrides the stall with a flush.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_cycles/flush_cycles counters.
module hazard_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int SEL_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1D,
    input  logic [ADDR_WIDTH-1:0] rs2D,
    input  logic [ADDR_WIDTH-1:0] rdD,
    input  logic                  regwriteD,
    input  logic                  resultsrcD,
    input  logic                  pcsrcE,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic [SEL_WIDTH-1:0]  fwd1E,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_cycles,
`endif
    output logic [SEL_WIDTH-1:0]  fwd2E
);

    // Per-stage tracking, index 0 = Execute, DEPTH-1 = Writeback.
    logic [DEPTH-1:0]      r_vld;
    logic [DEPTH-1:0]      r_rw;
    logic [DEPTH-1:0]      r_ld;
    logic [ADDR_WIDTH-1:0] r_rd [DEPTH];
    // Sources of the instruction currently in Execute.
    logic [ADDR_WIDTH-1:0] r_rs1_e;
    logic [ADDR_WIDTH-1:0] r_rs2_e;

    logic w_stall_cond;
    logic w_bubble;

    // Stage index from which a producer's result can be forwarded.
    function automatic int req_stage(input logic is_load);
        return is_load ? LOAD_READY : ALU_READY;
    endfunction

    // Shift the tracked destinations down the pipe; a bubble enters on stall or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_rw[k]  <= 1'b0;
                r_ld[k]  <= 1'b0;
                r_rd[k]  <= '0;
            end
            r_rs1_e <= '0;
            r_rs2_e <= '0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_rw[k]  <= r_rw[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            if (w_bubble) begin
                r_vld[0] <= 1'b0;
                r_rw[0]  <= 1'b0;
                r_ld[0]  <= 1'b0;
                r_rd[0]  <= '0;
                r_rs1_e  <= '0;
                r_rs2_e  <= '0;
            end else begin
                r_vld[0] <= 1'b1;
                r_rw[0]  <= regwriteD;
                r_ld[0]  <= resultsrcD;
                r_rd[0]  <= rdD;
                r_rs1_e  <= rs1D;
                r_rs2_e  <= rs2D;
            end
        end
    end

    // Stall when a producer of a Decode source will still be unforwardable once the consumer reaches Execute.
    always_comb begin
        w_stall_cond = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (r_vld[k] && r_rw[k] && (r_rd[k] != '0) &&
                ((r_rd[k] == rs1D) || (r_rd[k] == rs2D)) &&
                ((k + 1) < req_stage(r_ld[k]))) begin
                w_stall_cond = 1'b1;
            end
        end
    end

    // A taken branch kills the Decode instruction, so it must never hold the pipe.
    always_comb begin
        stallD   = w_stall_cond & ~pcsrcE;
        stallF   = stallD;
        flushD   = pcsrcE;
        flushE   = pcsrcE | stallD;
        w_bubble = stallD | pcsrcE;
    end

    // Forwarding: walk oldest to youngest so the youngest ready producer is the last one assigned.
    always_comb begin
        fwd1E = '0;
        fwd2E = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (r_vld[k] && r_rw[k] && (r_rd[k] != '0) && (k >= req_stage(r_ld[k]))) begin
                if (r_rd[k] == r_rs1_e) fwd1E = SEL_WIDTH'(k);
                if (r_rd[k] == r_rs2_e) fwd2E = SEL_WIDTH'(k);
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    // Saturating event counters for stall and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (stallD && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (pcsrcE && (r_flush_cycles != 32'hFFFF_FFFF)) r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with default parameters (DEPTH=3, ALU_READY=1, LOAD_READY=2).
// Inputs change 1ns after the rising edge; combinational outputs are sampled 2ns later.
// Optional counters are exercised when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rdD;
    logic       regwriteD, resultsrcD, pcsrcE;
    logic       stallF, stallD, flushD, flushE;
    logic [1:0] fwd1E, fwd2E;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int errs   = 0;
    int checks = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rdD        (rdD),
        .regwriteD  (regwriteD),
        .resultsrcD (resultsrcD),
        .pcsrcE     (pcsrcE),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .fwd1E      (fwd1E),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles),
`endif
        .fwd2E      (fwd2E)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic rw, input logic ld);
        rs1D = s1; rs2D = s2; rdD = d; regwriteD = rw; resultsrcD = ld;
    endtask

    task automatic nop();
        set_d(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        pcsrcE = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pcsrcE = 1'b1;
        set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
            errs++; $display("FAIL reset_flush got=%b exp=0011", {stallF, stallD, flushD, flushE});
        end
        tick(); tick();
        pcsrcE = 1'b0;
        #2;
        checks++;
        if ({stallF, stallD, fwd1E, fwd2E} !== 6'b0) begin
            errs++; $display("FAIL reset_state got=%b exp=000000", {stallF, stallD, fwd1E, fwd2E});
        end
        tick();
        rst = 1'b0;
        set_d(5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
            errs++; $display("FAIL reset_no_stall got=%b exp=0000", {stallF, stallD, flushD, flushE});
        end
        tick();
    endtask

    task automatic test_alu_chain();
        drain();
        set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        set_d(5'd5, 5'd5, 5'd8, 1'b1, 1'b0);
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
            errs++; $display("FAIL alu_no_stall got=%b exp=0000", {stallF, stallD, flushD, flushE});
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== {2'd1, 2'd1}) begin
            errs++; $display("FAIL alu_fwd_k1 got=%0d/%0d exp=1/1", fwd1E, fwd2E);
        end
        drain();
        set_d(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        tick();
        nop();
        tick();
        set_d(5'd5, 5'd5, 5'd8, 1'b1, 1'b0);
        #2;
        checks++;
        if (stallD !== 1'b0) begin
            errs++; $display("FAIL alu_gap_no_stall got=%b exp=0", stallD);
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== {2'd2, 2'd2}) begin
            errs++; $display("FAIL alu_fwd_k2 got=%0d/%0d exp=2/2", fwd1E, fwd2E);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd6, 5'd10, 1'b1, 1'b0);
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b1101) begin
            errs++; $display("FAIL lu_stall got=%b exp=1101", {stallF, stallD, flushD, flushE});
        end
        tick();
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
            errs++; $display("FAIL lu_one_cycle got=%b exp=0000", {stallF, stallD, flushD, flushE});
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== {2'd0, 2'd2}) begin
            errs++; $display("FAIL lu_fwd got=%0d/%0d exp=0/2", fwd1E, fwd2E);
        end
        // Load two ahead of its consumer is already forwardable: no stall.
        drain();
        set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
        tick();
        nop();
        tick();
        set_d(5'd6, 5'd0, 5'd10, 1'b1, 1'b0);
        #2;
        checks++;
        if (stallD !== 1'b0) begin
            errs++; $display("FAIL lu_gap_no_stall got=%b exp=0", stallD);
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== {2'd2, 2'd0}) begin
            errs++; $display("FAIL lu_gap_fwd got=%0d/%0d exp=2/0", fwd1E, fwd2E);
        end
    endtask

    task automatic test_x0_youngest();
        // Load to x0 must not stall an x0 reader.
        drain();
        set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        #2;
        checks++;
        if (stallD !== 1'b0) begin
            errs++; $display("FAIL x0_load_no_stall got=%b exp=0", stallD);
        end
        // ALU write to x0 must not be forwarded.
        drain();
        set_d(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== 4'b0) begin
            errs++; $display("FAIL x0_no_fwd got=%0d/%0d exp=0/0", fwd1E, fwd2E);
        end
        // Two writers of x7: the younger one (stage 1) wins.
        drain();
        set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_d(5'd7, 5'd0, 5'd11, 1'b1, 1'b0);
        #2;
        checks++;
        if (stallD !== 1'b0) begin
            errs++; $display("FAIL young_no_stall got=%b exp=0", stallD);
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== {2'd1, 2'd0}) begin
            errs++; $display("FAIL young_fwd got=%0d/%0d exp=1/0", fwd1E, fwd2E);
        end
    endtask

    task automatic test_flush_priority();
        drain();
        set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
        tick();
        // Wrong-path load to x9 that also depends on the load in E.
        set_d(5'd0, 5'd6, 5'd9, 1'b1, 1'b1);
        pcsrcE = 1'b1;
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
            errs++; $display("FAIL flush_prio got=%b exp=0011", {stallF, stallD, flushD, flushE});
        end
        tick();
        pcsrcE = 1'b0;
        set_d(5'd9, 5'd9, 5'd12, 1'b1, 1'b0);
        #2;
        checks++;
        if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
            errs++; $display("FAIL flush_bubble got=%b exp=0000", {stallF, stallD, flushD, flushE});
        end
        tick();
        nop();
        #2;
        checks++;
        if ({fwd1E, fwd2E} !== 4'b0) begin
            errs++; $display("FAIL flush_no_fwd got=%0d/%0d exp=0/0", fwd1E, fwd2E);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        pcsrcE = 1'b0;
        nop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_d(5'd0, 5'd0, 5'd6, 1'b1, 1'b1);
            tick();
            set_d(5'd0, 5'd6, 5'd10, 1'b1, 1'b0);
            tick();
            tick();
        end
        nop();
        for (int i = 0; i < 2; i++) begin
            pcsrcE = 1'b1;
            tick();
            pcsrcE = 1'b0;
            tick();
        end
        #2;
        checks++;
        if ({stall_cycles, flush_cycles} !== {32'd3, 32'd2}) begin
            errs++; $display("FAIL stats_count got=%0d/%0d exp=3/2", stall_cycles, flush_cycles);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if ({stall_cycles, flush_cycles} !== 64'd0) begin
            errs++; $display("FAIL stats_clear got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        pcsrcE = 1'b0;
        nop();
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0_youngest();
        test_flush_priority();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
